multiport_table_ram: RTL and testbench
======================================

Name: multiport_table_ram

Overview:
- Parametrised successor to the team's combinational multi-output lookup ROM.
- NUM_PORTS independent read ports, each with a registered 1-cycle read and a valid flag, plus one write port so the table is reloadable at run time.
- After reset, an internal init sequencer fills every entry with INIT_VAL before accepting traffic.
- Feeds the predictor's parallel coefficient/history lookups.

Parameters:
- NUM_PORTS, 16, number of read ports.
- DATAWIDTH, 2, bits per entry.
- DEPTHBITS, 3, address width.
- DATADEPTH, 1<<DEPTHBITS, number of entries (derived; not overridden).
- INIT_VAL, 2'b10 (DATAWIDTH bits), value written to every entry during init.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ready  output  1  high when init is done and requests are accepted.
- wr_en  input  1  write strobe.
- wr_addr  input  DEPTHBITS  write address.
- wr_data  input  DATAWIDTH  write data.
- rd_en  input  NUM_PORTS  per-port read strobe; bit i belongs to port i.
- rd_addr  input  NUM_PORTS*DEPTHBITS  port i at [i*DEPTHBITS +: DEPTHBITS].
- rd_data  output  NUM_PORTS*DATAWIDTH  port i at [i*DATAWIDTH +: DATAWIDTH].
- rd_valid  output  NUM_PORTS  rd_data slice i is valid this cycle.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=INIT, init_ptr=0.
  - ready=0, rd_valid=0, rd_data=0.
  - Memory contents are not touched by rst itself.
- FSM states INIT, RUN.
- INIT:
  - Each edge with rst=0 writes INIT_VAL to mem[init_ptr] and increments init_ptr.
  - The edge that writes entry DATADEPTH-1 moves state to RUN and sets ready=1.
  - So ready rises exactly DATADEPTH edges after rst deasserts.
  - wr_en and rd_en are ignored; writes are discarded and rd_valid stays 0.
- RUN write: at an edge with wr_en=1, mem[wr_addr] <= wr_data.
- RUN read:
  - Port i samples rd_en[i] and its rd_addr slice at an edge.
  - If rd_en[i]=1: next cycle rd_data[i]=mem[addr] and rd_valid[i]=1.
  - If rd_en[i]=0: rd_valid[i]=0 next cycle and rd_data[i] holds its last value.
  - Latency is exactly 1 cycle. There is no backpressure; every port can accept a read every cycle.
- Collisions:
  - Any number of ports may read the same address in the same cycle; all get identical data.
  - Read and write to the same address in the same cycle: the read returns the pre-write value (see the optional feature for the alternative).
- Address widths equal DEPTHBITS, so out-of-range addresses cannot occur.
- Reset mid-operation (INIT or RUN):
  - Aborts all in-flight reads; rd_valid=0 on the following cycle.
  - Restarts the full init sweep.
  - All prior writes are overwritten with INIT_VAL.
- ready only changes 0->1 at the end of INIT and 1->0 on rst.

Optional Feature:
- Macro MULTIPORT_TABLE_RAM_WRITE_BYPASS_EN.
- Defined: in RUN, if wr_en=1 and a reading port's address equals wr_addr in the same cycle, that port returns wr_data (write-first forwarding). Latency and valid behaviour are unchanged.
- Undefined: read-first; the port returns the old entry.
- Init behaviour is identical in both builds.

Decomposition:
- Shared package ts_ram_pkg holds:
  - typedef state_t {INIT, RUN}.
  - Default constants: NUM_PORTS_DEF, DATAWIDTH_DEF, DEPTHBITS_DEF.
  - Slice-index helper function for the flattened buses.
- One sub-module, multiport_table_rd_port: a single registered read port.
  - Inputs: en, addr, mem read value, bypass compare inputs.
  - Outputs: data, valid.
  - The top level instantiates it NUM_PORTS times in a generate loop.
- The memory array, write logic and init FSM stay in the top level.

Test Plan:
- Reset, defaults: rst high 2 cycles, then low -> ready=0 for 8 edges, ready=1 after the 8th. Reading all 16 ports at addresses 0..7 (wrapping) returns 2'b10 with rd_valid=16'hFFFF one cycle later.
- Write mem[3]=2'b01, then next cycle read all 16 ports at addr 3 -> all rd_data slices 2'b01, rd_valid=16'hFFFF exactly 1 cycle after the request.
- Same cycle: wr_en addr5 data 2'b11 and port0 reads addr5 -> returns 2'b10 (macro undefined) or 2'b11 (macro defined). A read of addr5 the following cycle returns 2'b11 in both builds.
- rd_en=16'hAAAA on varied addresses -> rd_valid=16'hAAAA; even-numbered ports hold their previous rd_data unchanged.
- In RUN after writing mem[3]=2'b01, assert rst for 1 cycle -> ready=0 and rd_valid=0 next cycle. After 8 edges ready=1, and reading addr3 returns 2'b10.
- During INIT drive rd_en=16'hFFFF and wr_en to addr0 with 2'b00 -> rd_valid stays 0. After ready, addr0 reads 2'b10 (write discarded).

Source files
------------

// File: rtl/ts_ram_pkg.sv
// Shared types, default sizes and bus-slicing helper for the multiport table RAM.
package ts_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_PORTS_DEF = 16;
    localparam int DATAWIDTH_DEF = 2;
    localparam int DEPTHBITS_DEF = 3;

    // Low bit index of element idx in a flattened bus of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/multiport_table_rd_port.sv
// One registered read port of the table RAM: 1-cycle latency, valid flag,
// data holds when not enabled.
// Optional macro MULTIPORT_TABLE_RAM_WRITE_BYPASS_EN: forward same-cycle write
// data to a read of the same address (write-first); otherwise read-first.
module multiport_table_rd_port
    import ts_ram_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int DEPTHBITS = DEPTHBITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DEPTHBITS-1:0] addr,
    input  logic [DATAWIDTH-1:0] mem_data,
    input  logic                 wr_en,
    input  logic [DEPTHBITS-1:0] wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic [DATAWIDTH-1:0] data,
    output logic                 valid
);

    logic [DATAWIDTH-1:0] rd_value;

`ifdef MULTIPORT_TABLE_RAM_WRITE_BYPASS_EN
    // Write-first: a same-cycle write to this address wins over the stored entry.
    always_comb begin
        rd_value = mem_data;
        if (wr_en && (wr_addr == addr)) begin
            rd_value = wr_data;
        end
    end
`else
    // Read-first: the stored entry is returned; the write inputs are not needed.
    logic bypass_unused;
    assign bypass_unused = &{1'b0, wr_en, wr_addr, wr_data};

    always_comb begin
        rd_value = mem_data;
    end
`endif

    // Output register: capture on enable, valid mirrors the enable one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= en;
            if (en) begin
                data <= rd_value;
            end
        end
    end

endmodule

// File: rtl/multiport_table_ram.sv
// Multiport table RAM: NUM_PORTS registered read ports, one write port, and an
// init sweep after reset that fills every entry with INIT_VAL.
// Optional macro MULTIPORT_TABLE_RAM_WRITE_BYPASS_EN (see multiport_table_rd_port).
module multiport_table_ram
    import ts_ram_pkg::*;
#(
    parameter int                   NUM_PORTS = NUM_PORTS_DEF,
    parameter int                   DATAWIDTH = DATAWIDTH_DEF,
    parameter int                   DEPTHBITS = DEPTHBITS_DEF,
    parameter logic [DATAWIDTH-1:0] INIT_VAL  = 2'b10
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           ready,
    input  logic                           wr_en,
    input  logic [DEPTHBITS-1:0]           wr_addr,
    input  logic [DATAWIDTH-1:0]           wr_data,
    input  logic [NUM_PORTS-1:0]           rd_en,
    input  logic [NUM_PORTS*DEPTHBITS-1:0] rd_addr,
    output logic [NUM_PORTS*DATAWIDTH-1:0] rd_data,
    output logic [NUM_PORTS-1:0]           rd_valid
);

    localparam int DATADEPTH = 1 << DEPTHBITS;
    localparam logic [DEPTHBITS-1:0] LAST_ADDR = DEPTHBITS'(DATADEPTH - 1);

    state_t               state;
    state_t               state_next;
    logic [DEPTHBITS-1:0] init_ptr;
    logic                 run;
    logic [DATAWIDTH-1:0] mem [DATADEPTH];

    assign run = (state == RUN);

    // Init sequencer state register: sweep pointer, state and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_ptr <= '0;
            ready    <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == RUN);
            if (state == INIT) begin
                init_ptr <= init_ptr + 1'b1;
            end
        end
    end

    // Next state: leave INIT on the edge that writes the last entry.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (init_ptr == LAST_ADDR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Memory write: init sweep owns the array in INIT, user write port in RUN.
    // Reset edges never write, so contents only change through these paths.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[init_ptr] <= INIT_VAL;
            end else if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DEPTHBITS-1:0] addr_p;
        logic [DATAWIDTH-1:0] mem_q;

        assign addr_p = rd_addr[slice_lo(p, DEPTHBITS) +: DEPTHBITS];
        assign mem_q  = mem[addr_p];

        multiport_table_rd_port #(
            .DATAWIDTH (DATAWIDTH),
            .DEPTHBITS (DEPTHBITS)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .en       (rd_en[p] & run),
            .addr     (addr_p),
            .mem_data (mem_q),
            .wr_en    (wr_en & run),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[slice_lo(p, DATAWIDTH) +: DATAWIDTH]),
            .valid    (rd_valid[p])
        );
    end

endmodule

// File: tb/tb_multiport_table_ram.sv
// Scoreboard bench for multiport_table_ram with directed vectors.
module tb_multiport_table_ram;

    localparam int NP = 16;
    localparam int DW = 2;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NP-1:0]     rd_en;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic [NP-1:0]     rd_valid;

    multiport_table_ram dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               cyc;
        logic [NP-1:0]    vld;
        logic [NP*DW-1:0] data;
    } exp_t;

    exp_t             sb[$];
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    logic [NP*DW-1:0] exp_hold = '0;

    always @(posedge clk) cyc++;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (rd_valid !== e.vld) begin
                n_fail++;
                $display("FAIL rd_valid cyc=%0d got=%h exp=%h", e.cyc, rd_valid, e.vld);
            end
            n_tests++;
            if (rd_data !== e.data) begin
                n_fail++;
                $display("FAIL rd_data cyc=%0d got=%h exp=%h", e.cyc, rd_data, e.data);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [NP*AW-1:0] addr_all(input logic [AW-1:0] a);
        logic [NP*AW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*AW +: AW] = a;
        return v;
    endfunction

    function automatic logic [NP*AW-1:0] addr_mod();
        logic [NP*AW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*AW +: AW] = AW'(i % 8);
        return v;
    endfunction

    function automatic logic [NP*DW-1:0] vals_all(input logic [DW-1:0] d);
        logic [NP*DW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*DW +: DW] = d;
        return v;
    endfunction

    // One clock: drive inputs, record what the outputs must show after the edge.
    task automatic step(input logic r, input logic [NP-1:0] en, input logic [NP*AW-1:0] addr,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NP-1:0] ev, input logic [NP*DW-1:0] evals);
        exp_t e;
        rst = r; rd_en = en; rd_addr = addr;
        wr_en = we; wr_addr = wa; wr_data = wd;
        if (r) exp_hold = '0;
        else
            for (int i = 0; i < NP; i++)
                if (ev[i]) exp_hold[i*DW +: DW] = evals[i*DW +: DW];
        e.cyc  = cyc + 1;
        e.vld  = r ? '0 : ev;
        e.data = exp_hold;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [NP*DW-1:0] v4;
        logic [DW-1:0]    tbl [8];
        logic [DW-1:0]    bypass_exp;

        // Reset held two cycles.
        step(1'b1, '0, '0, 1'b0, '0, '0, '0, '0);
        check("ready_in_reset", {31'd0, ready}, 32'd0);
        step(1'b1, '0, '0, 1'b0, '0, '0, '0, '0);

        // Init sweep with reads and a write to addr0 that must be ignored.
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 16'hFFFF, addr_mod(), 1'b1, 3'd0, 2'b00, '0, '0);
            check($sformatf("ready_init_edge%0d", k), {31'd0, ready}, (k == 8) ? 32'd1 : 32'd0);
        end

        // All ports read addresses 0..7 wrapping: every entry is INIT_VAL.
        step(1'b0, 16'hFFFF, addr_mod(), 1'b0, '0, '0, 16'hFFFF, vals_all(2'b10));
        idle();

        // Write mem[3]=01, then all ports read addr3.
        step(1'b0, '0, '0, 1'b1, 3'd3, 2'b01, '0, '0);
        step(1'b0, 16'hFFFF, addr_all(3'd3), 1'b0, '0, '0, 16'hFFFF, vals_all(2'b01));
        idle();

        // Same-cycle write/read collision on addr5.
`ifdef MULTIPORT_TABLE_RAM_WRITE_BYPASS_EN
        bypass_exp = 2'b11;
`else
        bypass_exp = 2'b10;
`endif
        step(1'b0, 16'h0001, addr_all(3'd5), 1'b1, 3'd5, 2'b11, 16'h0001, vals_all(bypass_exp));
        step(1'b0, 16'h0001, addr_all(3'd5), 1'b0, '0, '0, 16'h0001, vals_all(2'b11));

        // Odd ports read addr i%8; even ports keep their previous data.
        tbl[0] = 2'b10; tbl[1] = 2'b10; tbl[2] = 2'b10; tbl[3] = 2'b01;
        tbl[4] = 2'b10; tbl[5] = 2'b11; tbl[6] = 2'b10; tbl[7] = 2'b10;
        for (int i = 0; i < NP; i++) v4[i*DW +: DW] = tbl[i % 8];
        step(1'b0, 16'hAAAA, addr_mod(), 1'b0, '0, '0, 16'hAAAA, v4);
        check("ready_run", {31'd0, ready}, 32'd1);
        idle();

        // Reset in RUN with reads in flight: sweep restarts and overwrites mem[3].
        step(1'b0, 16'hFFFF, addr_all(3'd2), 1'b1, 3'd3, 2'b01, 16'hFFFF, vals_all(2'b10));
        step(1'b1, 16'hFFFF, addr_all(3'd3), 1'b0, '0, '0, '0, '0);
        check("ready_after_rst", {31'd0, ready}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
            check($sformatf("ready_reinit_edge%0d", k), {31'd0, ready}, (k == 8) ? 32'd1 : 32'd0);
        end
        step(1'b0, 16'hFFFF, addr_all(3'd3), 1'b0, '0, '0, 16'hFFFF, vals_all(2'b10));
        step(1'b0, 16'hFFFF, addr_all(3'd0), 1'b0, '0, '0, 16'hFFFF, vals_all(2'b10));
        idle();

        // Drain the scoreboard within a bounded number of cycles.
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
